// File: rtl/lfsr_pkg.sv
// Shared definitions for the multi-channel XNOR LFSR: tap table, width limits, FSM states.
package lfsr_pkg;

  localparam int unsigned LFSR_MIN_BITS = 3;
  localparam int unsigned LFSR_MAX_BITS = 32;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StSettle
  } lfsr_state_e;

  // Tap k lives at state bit k-1.
  function automatic logic [31:0] tap_bit(input int unsigned k);
    return 32'd1 << (k - 1);
  endfunction

  // Maximal-length XNOR tap sets (XAPP052) for widths 3..32; unsupported widths give 0.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] mask;
    mask = '0;
    case (width)
      3:  mask = tap_bit(3)  | tap_bit(2);
      4:  mask = tap_bit(4)  | tap_bit(3);
      5:  mask = tap_bit(5)  | tap_bit(3);
      6:  mask = tap_bit(6)  | tap_bit(5);
      7:  mask = tap_bit(7)  | tap_bit(6);
      8:  mask = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:  mask = tap_bit(9)  | tap_bit(5);
      10: mask = tap_bit(10) | tap_bit(7);
      11: mask = tap_bit(11) | tap_bit(9);
      12: mask = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13: mask = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14: mask = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15: mask = tap_bit(15) | tap_bit(14);
      16: mask = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: mask = tap_bit(17) | tap_bit(14);
      18: mask = tap_bit(18) | tap_bit(11);
      19: mask = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20: mask = tap_bit(20) | tap_bit(17);
      21: mask = tap_bit(21) | tap_bit(19);
      22: mask = tap_bit(22) | tap_bit(21);
      23: mask = tap_bit(23) | tap_bit(18);
      24: mask = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: mask = tap_bit(25) | tap_bit(22);
      26: mask = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27: mask = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28: mask = tap_bit(28) | tap_bit(25);
      29: mask = tap_bit(29) | tap_bit(27);
      30: mask = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31: mask = tap_bit(31) | tap_bit(28);
      32: mask = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_multi_if.sv
// Seed-write and random-word stream bundle for lfsr_multi.
interface lfsr_multi_if #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                       i_Seed_DV;
  logic [CH_W-1:0]            i_Seed_Ch;
  logic [NUM_BITS-1:0]        i_Seed_Data;
  logic                       o_Seed_Ready;
  logic                       o_Seed_Err;
  logic [NUM_CH*NUM_BITS-1:0] o_Data;
  logic                       o_Valid;
  logic                       i_Ready;
  logic [NUM_CH-1:0]          o_Wrap;

  // Random source side.
  modport master (
    input  i_Seed_DV, i_Seed_Ch, i_Seed_Data, i_Ready,
    output o_Seed_Ready, o_Seed_Err, o_Data, o_Valid, o_Wrap
  );

  // Consumer / seeding side.
  modport slave (
    output i_Seed_DV, i_Seed_Ch, i_Seed_Data, i_Ready,
    input  o_Seed_Ready, o_Seed_Err, o_Data, o_Valid, o_Wrap
  );
endinterface

// File: rtl/lfsr_multi_step.sv
// Combinational STEP-shift next state for one XNOR Fibonacci LFSR channel.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned STEP     = 1
) (
  input  logic [NUM_BITS-1:0] state,
  output logic [NUM_BITS-1:0] next_state
);

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(lfsr_taps(NUM_BITS));

  logic [NUM_BITS-1:0] acc;

  // Unrolled chain of single shifts; feedback is the XNOR of the tapped bits.
  always_comb begin
    acc = state;
    for (int i = 0; i < int'(STEP); i++) begin
      acc = {acc[NUM_BITS-2:0], ~(^(acc & TAPS))};
    end
    next_state = acc;
  end

endmodule

// File: rtl/lfsr_multi.sv
// Multi-channel XNOR LFSR random source with valid/ready output, runtime seeding and wrap pulses.
module lfsr_multi
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned STEP     = 1,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  lfsr_multi_if.master   bus
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0][NUM_BITS-1:0] state_q;
  logic [NUM_CH-1:0][NUM_BITS-1:0] ref_q;
  logic [NUM_CH-1:0][NUM_BITS-1:0] next_state;
  lfsr_state_e                     fsm_q;
  logic                            valid_q;
  logic                            seed_ready_q;
  logic                            seed_err_q;
  logic [NUM_CH-1:0]               wrap_q;

  logic                            seed_acc;
  logic                            seed_bad;
  logic                            advance;
  logic [NUM_CH-1:0]               seed_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lfsr_step #(
      .NUM_BITS (NUM_BITS),
      .STEP     (STEP)
    ) u_step (
      .state      (state_q[c]),
      .next_state (next_state[c])
    );
  end

  // Seed decode and handshake; ready/valid flags are only ever high in RUN.
  always_comb begin
    seed_acc = bus.i_Seed_DV & seed_ready_q;
    seed_bad = (&bus.i_Seed_Data) | ({1'b0, bus.i_Seed_Ch} >= CH_LIMIT);
    advance  = valid_q & bus.i_Ready;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      seed_hit[c] = seed_acc & ~seed_bad & (bus.i_Seed_Ch == CH_W'(c));
    end
  end

  // FSM, channel state, reference seeds and registered status pulses.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fsm_q        <= StInit;
      valid_q      <= 1'b0;
      seed_ready_q <= 1'b0;
      seed_err_q   <= 1'b0;
      wrap_q       <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        state_q[c] <= NUM_BITS'(c);
        ref_q[c]   <= NUM_BITS'(c);
      end
    end else begin
      seed_err_q <= 1'b0;
      wrap_q     <= '0;
      case (fsm_q)
        StInit, StSettle: begin
          fsm_q        <= StRun;
          valid_q      <= 1'b1;
          seed_ready_q <= 1'b1;
        end
        StRun: begin
          if (seed_acc) begin
            fsm_q        <= StSettle;
            valid_q      <= 1'b0;
            seed_ready_q <= 1'b0;
            seed_err_q   <= seed_bad;
          end
        end
        default: begin
          fsm_q        <= StInit;
          valid_q      <= 1'b0;
          seed_ready_q <= 1'b0;
        end
      endcase
      // A seeded channel takes the seed; the rest follow the stream handshake.
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (seed_hit[c]) begin
          state_q[c] <= bus.i_Seed_Data;
          ref_q[c]   <= bus.i_Seed_Data;
        end else if (advance) begin
          state_q[c] <= next_state[c];
          wrap_q[c]  <= (next_state[c] == ref_q[c]);
        end
      end
    end
  end

  assign bus.o_Data       = state_q;
  assign bus.o_Valid      = valid_q;
  assign bus.o_Seed_Ready = seed_ready_q;
  assign bus.o_Seed_Err   = seed_err_q;
  assign bus.o_Wrap       = wrap_q;

endmodule

// File: tb/tb_lfsr_multi.sv
// Directed bench for lfsr_multi: a 4-bit/3-channel instance and a 32-bit/STEP=8 instance.
module tb_lfsr_multi;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_checks = 0;
  int n_fail   = 0;

  // 4-bit XNOR sequence from 0 (taps 4,3), period 15.
  logic [3:0] seq [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                           4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

  lfsr_multi_if #(.NUM_BITS(4),  .NUM_CH(3)) bus_a ();
  lfsr_multi_if #(.NUM_BITS(32), .NUM_CH(2)) bus_b ();

  lfsr_multi #(.NUM_BITS(4), .STEP(1), .NUM_CH(3)) u_dut_a (
    .i_Clk (clk),
    .i_Rst (rst_a),
    .bus   (bus_a)
  );

  lfsr_multi #(.NUM_BITS(32), .STEP(8), .NUM_CH(2)) u_dut_b (
    .i_Clk (clk),
    .i_Rst (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word for 4-bit instance given sequence indices of ch0, ch1, ch2.
  function automatic logic [11:0] exp_word(input int i0, input int i1, input int i2);
    return {seq[i2 % 15], seq[i1 % 15], seq[i0 % 15]};
  endfunction

  function automatic logic [31:0] step32(input logic [31:0] s);
    logic fb;
    fb = ~(s[31] ^ s[21] ^ s[1] ^ s[0]);
    return {s[30:0], fb};
  endfunction

  // Pulse reset on the 4-bit instance; returns at the first valid-word negedge.
  task automatic pulse_reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first0, first1, cnt1, wraps;
    logic [31:0] m0, m1;

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.i_Seed_DV = 1'b0;  bus_a.i_Seed_Ch = '0;  bus_a.i_Seed_Data = '0;  bus_a.i_Ready = 1'b1;
    bus_b.i_Seed_DV = 1'b0;  bus_b.i_Seed_Ch = '0;  bus_b.i_Seed_Data = '0;  bus_b.i_Ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_valid", 64'(bus_a.o_Valid), 64'd0);
    check("rst_seed_ready", 64'(bus_a.o_Seed_Ready), 64'd0);
    check("rst_seed_err", 64'(bus_a.o_Seed_Err), 64'd0);
    check("rst_wrap", 64'(bus_a.o_Wrap), 64'd0);
    check("rst_data", 64'(bus_a.o_Data), 64'h210);

    // INIT lasts one cycle, then free-running words.
    rst_a = 1'b0;
    @(negedge clk);
    check("run_valid", 64'(bus_a.o_Valid), 64'd1);
    check("run_seed_ready", 64'(bus_a.o_Seed_Ready), 64'd1);
    for (int n = 0; n < 5; n++) begin
      check("run_data", 64'(bus_a.o_Data), 64'(exp_word(n, n + 1, n + 10)));
      @(negedge clk);
    end

    // Stall with ready low: word held at ch0=3, ch1=7.
    pulse_reset_a();
    repeat (2) @(negedge clk);
    bus_a.i_Ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_data", 64'(bus_a.o_Data), 64'(exp_word(2, 3, 12)));
      check("stall_valid", 64'(bus_a.o_Valid), 64'd1);
    end
    bus_a.i_Ready = 1'b1;
    @(negedge clk);
    check("resume_data0", 64'(bus_a.o_Data), 64'(exp_word(3, 4, 13)));
    @(negedge clk);
    check("resume_data1", 64'(bus_a.o_Data), 64'(exp_word(4, 5, 14)));

    // Seed ch1=5 together with an accepted word: ch0/ch2 advance, ch1 takes the seed.
    pulse_reset_a();
    bus_a.i_Seed_DV = 1'b1;  bus_a.i_Seed_Ch = 2'd1;  bus_a.i_Seed_Data = 4'h5;
    @(negedge clk);
    bus_a.i_Seed_DV = 1'b0;
    check("settle_valid", 64'(bus_a.o_Valid), 64'd0);
    check("settle_seed_ready", 64'(bus_a.o_Seed_Ready), 64'd0);
    check("settle_seed_err", 64'(bus_a.o_Seed_Err), 64'd0);
    check("settle_wrap", 64'(bus_a.o_Wrap), 64'd0);
    check("settle_data", 64'(bus_a.o_Data), 64'h551);
    @(negedge clk);
    check("seeded_valid", 64'(bus_a.o_Valid), 64'd1);
    check("seeded_data", 64'(bus_a.o_Data), 64'h551);
    first0 = -1;
    first1 = -1;
    cnt1   = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus_a.o_Wrap[1]) begin
        cnt1++;
        if (first1 < 0) first1 = k;
      end
      if (bus_a.o_Wrap[0] && first0 < 0) first0 = k;
    end
    check("wrap1_at", 64'(first1), 64'd15);
    check("wrap1_count", 64'(cnt1), 64'd1);
    check("wrap0_at", 64'(first0), 64'd14);

    // Rejected seeds with the stream stalled: ch0=3, ch1=A, ch2=A throughout.
    bus_a.i_Ready = 1'b0;
    @(negedge clk);
    check("pre_rej_data", 64'(bus_a.o_Data), 64'hAA3);
    bus_a.i_Seed_DV = 1'b1;  bus_a.i_Seed_Ch = 2'd0;  bus_a.i_Seed_Data = 4'hF;
    @(negedge clk);
    bus_a.i_Seed_DV = 1'b0;
    check("rej_ones_err", 64'(bus_a.o_Seed_Err), 64'd1);
    check("rej_ones_valid", 64'(bus_a.o_Valid), 64'd0);
    check("rej_ones_data", 64'(bus_a.o_Data), 64'hAA3);
    @(negedge clk);
    check("rej_ones_err_off", 64'(bus_a.o_Seed_Err), 64'd0);
    check("rej_ones_valid_back", 64'(bus_a.o_Valid), 64'd1);
    bus_a.i_Seed_DV = 1'b1;  bus_a.i_Seed_Ch = 2'd3;  bus_a.i_Seed_Data = 4'h3;
    @(negedge clk);
    bus_a.i_Seed_DV = 1'b0;
    check("rej_ch_err", 64'(bus_a.o_Seed_Err), 64'd1);
    check("rej_ch_valid", 64'(bus_a.o_Valid), 64'd0);
    check("rej_ch_data", 64'(bus_a.o_Data), 64'hAA3);
    @(negedge clk);
    check("rej_ch_err_off", 64'(bus_a.o_Seed_Err), 64'd0);
    check("rej_ch_data_after", 64'(bus_a.o_Data), 64'hAA3);

    // Reset during a stalled handshake with a pending seed.
    bus_a.i_Seed_DV = 1'b1;  bus_a.i_Seed_Ch = 2'd1;  bus_a.i_Seed_Data = 4'h6;
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(bus_a.o_Valid), 64'd0);
    check("mid_rst_seed_ready", 64'(bus_a.o_Seed_Ready), 64'd0);
    check("mid_rst_data", 64'(bus_a.o_Data), 64'h210);
    rst_a = 1'b0;
    bus_a.i_Seed_DV = 1'b0;
    bus_a.i_Ready   = 1'b1;
    @(negedge clk);
    check("post_rst_err", 64'(bus_a.o_Seed_Err), 64'd0);
    check("post_rst_wrap", 64'(bus_a.o_Wrap), 64'd0);
    check("post_rst_data", 64'(bus_a.o_Data), 64'h210);

    // 32-bit, STEP=8: each word is 8 single steps of the model; no wrap seen.
    rst_b = 1'b0;
    @(negedge clk);
    m0    = 32'd0;
    m1    = 32'd1;
    wraps = 0;
    for (int n = 0; n < 3000; n++) begin
      check("w32_data", bus_b.o_Data, {m1, m0});
      if (|bus_b.o_Wrap) wraps++;
      for (int s = 0; s < 8; s++) begin
        m0 = step32(m0);
        m1 = step32(m1);
      end
      @(negedge clk);
    end
    check("w32_wraps", 64'(wraps), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
